// File: rtl/game_over_ctrl_if.sv
// Event and status bundle between the game-state controller and the sprite/banner logic.
// Latency: none (wires only); the controller registers everything it drives.
// Backpressure: none; events are one-cycle pulses or levels and are consumed every cycle.
interface game_over_ctrl_if;
  // Events into the controller
  logic       start_btn;
  logic       player_hit;
  logic       alien_killed;
  logic       alien_landed;
  // Game status out of the controller
  logic       loser;
  logic       winner;
  logic       playing;
  logic       invuln;
  logic       game_reset;
  logic [3:0] lives;
  logic [7:0] aliens_left;

  // Event source / status consumer side
  modport master (
    output start_btn, player_hit, alien_killed, alien_landed,
    input  loser, winner, playing, invuln, game_reset, lives, aliens_left
  );

  // Controller side
  modport slave (
    input  start_btn, player_hit, alien_killed, alien_landed,
    output loser, winner, playing, invuln, game_reset, lives, aliens_left
  );
endinterface

// File: rtl/game_over_ctrl.sv
// Game-state controller: lives/alien bookkeeping and IDLE/PLAYING/RESPAWN/LOSE/WIN sequencing.
// Latency: one cycle from an input sampled at a clk edge to the registered outputs.
// Backpressure: none; every event is acted on (or deliberately ignored) in the cycle it arrives.
module game_over_ctrl #(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned ALIEN_COUNT   = 55,
  parameter int unsigned INVULN_CYCLES = 31500000,
  parameter int unsigned HOLD_CYCLES   = 320000000
) (
  input  logic                  clk,
  input  logic                  rst,
  game_over_ctrl_if.slave       gif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAYING = 3'd1,
    S_RESPAWN = 3'd2,
    S_LOSE    = 3'd3,
    S_WIN     = 3'd4
  } state_t;

  // Timers count down to zero, so the load value is one less than the dwell time.
  localparam logic [31:0] INVULN_LOAD = 32'(INVULN_CYCLES - 1);
  localparam logic [31:0] HOLD_LOAD   = 32'(HOLD_CYCLES - 1);
  localparam logic [3:0]  LIVES_LOAD  = 4'(LIVES_INIT);
  localparam logic [7:0]  ALIEN_LOAD  = 8'(ALIEN_COUNT);

  state_t      state_q, state_d;
  logic [3:0]  lives_q, lives_d;
  logic [7:0]  aliens_q, aliens_d;
  logic [31:0] timer_q, timer_d;
  logic        start_prev_q;
  logic        game_reset_d;
  logic        loser_q, winner_q, playing_q, invuln_q, game_reset_q;

  logic        start_edge;
  logic [7:0]  aliens_after_kill;
  logic        hit_lethal;
  logic        hit_nonlethal;

  // start_prev resets high so a button held through reset release is not an edge.
  assign start_edge = gif.start_btn & ~start_prev_q;

  // Kill bookkeeping and hit classification shared by the in-game states.
  always_comb begin
    aliens_after_kill = aliens_q;
    if (gif.alien_killed && (aliens_q != 8'd0)) begin
      aliens_after_kill = aliens_q - 8'd1;
    end
    // Hits only count in PLAYING; RESPAWN is the invulnerable window.
    hit_lethal    = (state_q == S_PLAYING) && gif.player_hit && (lives_q <= 4'd1);
    hit_nonlethal = (state_q == S_PLAYING) && gif.player_hit && (lives_q >  4'd1);
  end

  // Next-state and counter logic; LOSE outranks WIN, WIN outranks a survivable hit.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    aliens_d     = aliens_q;
    timer_d      = timer_q;
    game_reset_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d      = S_PLAYING;
          lives_d      = LIVES_LOAD;
          aliens_d     = ALIEN_LOAD;
          game_reset_d = 1'b1;
        end
      end

      S_PLAYING, S_RESPAWN: begin
        aliens_d = aliens_after_kill;
        if (gif.alien_landed || hit_lethal) begin
          state_d = S_LOSE;
          lives_d = 4'd0;
          timer_d = HOLD_LOAD;
        end else if (aliens_after_kill == 8'd0) begin
          // A simultaneous survivable hit still costs a life.
          state_d = S_WIN;
          timer_d = HOLD_LOAD;
          if (hit_nonlethal) begin
            lives_d = lives_q - 4'd1;
          end
        end else if (hit_nonlethal) begin
          state_d = S_RESPAWN;
          lives_d = lives_q - 4'd1;
          timer_d = INVULN_LOAD;
        end else if (state_q == S_RESPAWN) begin
          if (timer_q == 32'd0) begin
            state_d = S_PLAYING;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
      end

      S_LOSE, S_WIN: begin
        if (timer_q == 32'd0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and the start-button history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lives_q      <= 4'd0;
      aliens_q     <= 8'd0;
      timer_q      <= 32'd0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      aliens_q     <= aliens_d;
      timer_q      <= timer_d;
      start_prev_q <= gif.start_btn;
    end
  end

  // Status flags registered from the next state so they line up with it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loser_q      <= 1'b0;
      winner_q     <= 1'b0;
      playing_q    <= 1'b0;
      invuln_q     <= 1'b0;
      game_reset_q <= 1'b0;
    end else begin
      loser_q      <= (state_d == S_LOSE);
      winner_q     <= (state_d == S_WIN);
      playing_q    <= (state_d == S_PLAYING) || (state_d == S_RESPAWN);
      invuln_q     <= (state_d == S_RESPAWN);
      game_reset_q <= game_reset_d;
    end
  end

  assign gif.loser       = loser_q;
  assign gif.winner      = winner_q;
  assign gif.playing     = playing_q;
  assign gif.invuln      = invuln_q;
  assign gif.game_reset  = game_reset_q;
  assign gif.lives       = lives_q;
  assign gif.aliens_left = aliens_q;

endmodule

// File: tb/tb_game_over_ctrl.sv
// Bench for game_over_ctrl: directed scenarios then random events against a behavioural model.
// Latency: outputs checked on the falling edge after each rising edge.
// Backpressure: none.
module tb_game_over_ctrl;

  localparam int LIVES   = 3;
  localparam int ALIENS  = 4;
  localparam int INVULN  = 10;
  localparam int HOLD    = 20;

  logic clk;
  logic rst;

  game_over_ctrl_if gif ();

  game_over_ctrl #(
    .LIVES_INIT    (LIVES),
    .ALIEN_COUNT   (ALIENS),
    .INVULN_CYCLES (INVULN),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .gif (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // Behavioural model: game phase plus the number of cycles still to spend in it.
  typedef enum int {P_IDLE, P_PLAY, P_RESP, P_LOSE, P_WIN} phase_t;
  phase_t m_phase;
  int     m_left;
  int     m_lives;
  int     m_aliens;
  bit     m_prev_btn;
  bit     m_greset;

  task automatic model_reset();
    m_phase    = P_IDLE;
    m_left     = 0;
    m_lives    = 0;
    m_aliens   = 0;
    m_prev_btn = 1'b1;
    m_greset   = 1'b0;
  endtask

  task automatic enter(input phase_t p);
    m_phase = p;
    m_left  = (p == P_RESP) ? INVULN : HOLD;
  endtask

  task automatic model_step(input bit sb, input bit hit, input bit kill, input bit landed);
    bit edge_seen, lethal, survivable;
    edge_seen  = sb && !m_prev_btn;
    m_prev_btn = sb;
    m_greset   = 1'b0;
    case (m_phase)
      P_IDLE: begin
        if (edge_seen) begin
          m_phase  = P_PLAY;
          m_lives  = LIVES;
          m_aliens = ALIENS;
          m_greset = 1'b1;
        end
      end
      P_PLAY, P_RESP: begin
        lethal     = (m_phase == P_PLAY) && hit && (m_lives == 1);
        survivable = (m_phase == P_PLAY) && hit && (m_lives > 1);
        if (kill && m_aliens > 0) m_aliens = m_aliens - 1;
        if (landed || lethal) begin
          m_lives = 0;
          enter(P_LOSE);
        end else if (m_aliens == 0) begin
          if (survivable) m_lives = m_lives - 1;
          enter(P_WIN);
        end else if (survivable) begin
          m_lives = m_lives - 1;
          enter(P_RESP);
        end else if (m_phase == P_RESP) begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = P_PLAY;
        end
      end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = P_IDLE;
      end
    endcase
  endtask

  task automatic check_all();
    chk("loser",       32'(gif.loser),       32'(m_phase == P_LOSE));
    chk("winner",      32'(gif.winner),      32'(m_phase == P_WIN));
    chk("playing",     32'(gif.playing),     32'(m_phase == P_PLAY || m_phase == P_RESP));
    chk("invuln",      32'(gif.invuln),      32'(m_phase == P_RESP));
    chk("game_reset",  32'(gif.game_reset),  32'(m_greset));
    chk("lives",       32'(gif.lives),       32'(m_lives));
    chk("aliens_left", 32'(gif.aliens_left), 32'(m_aliens));
  endtask

  // One clock: check the previous edge's result, drive new inputs, let the edge happen.
  task automatic cyc(input bit sb, input bit hit, input bit kill, input bit landed);
    @(negedge clk);
    check_all();
    gif.start_btn    = sb;
    gif.player_hit   = hit;
    gif.alien_killed = kill;
    gif.alien_landed = landed;
    @(posedge clk);
    model_step(sb, hit, kill, landed);
  endtask

  task automatic idle_cycles(input int n, input bit sb);
    for (int i = 0; i < n; i++) cyc(sb, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_game();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between clock edges must clear outputs before the next rising edge.
  task automatic mid_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_loser",   32'(gif.loser),       32'd0);
    chk("rst_winner",  32'(gif.winner),      32'd0);
    chk("rst_playing", 32'(gif.playing),     32'd0);
    chk("rst_invuln",  32'(gif.invuln),      32'd0);
    chk("rst_greset",  32'(gif.game_reset),  32'd0);
    chk("rst_lives",   32'(gif.lives),       32'd0);
    chk("rst_aliens",  32'(gif.aliens_left), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    gif.start_btn    = 1'b1;
    gif.player_hit   = 1'b0;
    gif.alien_killed = 1'b0;
    gif.alien_landed = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Button held through reset release must not start a game.
    idle_cycles(50, 1'b1);
    start_game();

    // One hit -> RESPAWN for exactly INVULN cycles; hits inside it are ignored.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b1, (i % 3) == 0, 1'b0, 1'b0);

    // Fresh game, three spaced hits -> LOSE held HOLD cycles, then IDLE.
    idle_cycles(2, 1'b1);
    mid_reset();
    start_game();
    for (int h = 0; h < 3; h++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle_cycles(INVULN + 2, 1'b1);
    end
    idle_cycles(HOLD + 5, 1'b1);

    // Four kills -> WIN; extra kills during WIN change nothing.
    start_game();
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles(HOLD + 3, 1'b1);

    // Last life and last alien in the same cycle -> LOSE wins.
    start_game();
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int h = 0; h < 2; h++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle_cycles(INVULN + 2, 1'b1);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    idle_cycles(HOLD + 3, 1'b1);

    // Survivable hit plus final kill -> WIN with the life still deducted.
    start_game();
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    idle_cycles(HOLD + 3, 1'b1);

    // Alien landing during RESPAWN, then reset in the middle of RESPAWN.
    start_game();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(3, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycles(HOLD + 3, 1'b1);
    start_game();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(3, 1'b1);
    mid_reset();
    start_game();
    idle_cycles(3, 1'b1);

    // Random event soup against the model.
    begin
      bit sb;
      sb = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 699) == 0) mid_reset();
        if ($urandom_range(0, 9) == 0) sb = ~sb;
        cyc(sb,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 5)  == 0,
            $urandom_range(0, 79) == 0);
      end
    end

    @(negedge clk);
    check_all();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
